// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the MaxNet winner-take-all engine.
package maxnet_pkg;
  localparam int DATA_W = 8;
  localparam int ITER_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  function automatic data_t sat_sub(data_t a, data_t b);
    return (a > b) ? data_t'(a - b) : '0;
  endfunction
endpackage

// File: rtl/maxnet_sum_tree.sv
// Combinational M-input adder tree; leaves padded to a power of two with zeros.
module maxnet_sum_tree #(
  parameter int M      = 10,
  parameter int DATA_W = 8
) (
  input  logic [M-1:0][DATA_W-1:0]      x,
  output logic [DATA_W+$clog2(M)-1:0]   sum
);
  localparam int SUM_W = DATA_W + $clog2(M);
  localparam int LVLS  = $clog2(M);
  localparam int P     = 1 << LVLS;

  logic [SUM_W-1:0] node [1:2*P-1];

  genvar i, k;
  generate
    for (i = 0; i < P; i++) begin : g_leaf
      if (i < M) begin : g_used
        assign node[P+i] = SUM_W'(x[i]);
      end else begin : g_pad
        assign node[P+i] = '0;
      end
    end
    // Heap-ordered tree: node k sums children 2k and 2k+1.
    for (k = 1; k < P; k++) begin : g_add
      assign node[k] = node[2*k] + node[2*k+1];
    end
  endgenerate

  assign sum = node[1];
endmodule

// File: rtl/maxnet_engine.sv
// MaxNet lateral-inhibition engine: snapshots po on start and iterates until <=1 node survives.
// Optional iteration limit enabled by defining MAXNET_TIMEOUT_EN.
module maxnet_engine
  import maxnet_pkg::*;
#(
  parameter int M         = 10,
  parameter int EPS_SHIFT = 4,
  parameter int MAX_ITER  = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [M-1:0][DATA_W-1:0]        po,
  output logic                            busy,
  output logic                            done,
  output logic                            winner_valid,
  output logic [((M>1)?$clog2(M):1)-1:0]  winner_idx,
  output logic [DATA_W-1:0]               winner_val,
  output logic [ITER_W-1:0]               iter_count,
  output logic                            timeout
);
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam int SUM_W = DATA_W + $clog2(M);
  localparam int NZ_W  = $clog2(M + 1);

  generate
    if ((1 << EPS_SHIFT) <= M) begin : g_bad_eps
      $error("maxnet_engine: eps must be below 1/M for convergence");
    end
    if (MAX_ITER < 0 || MAX_ITER > 255) begin : g_bad_iter
      $error("maxnet_engine: MAX_ITER must fit the iteration counter");
    end
  endgenerate

  state_t                     state, state_nxt;
  logic [M-1:0][DATA_W-1:0]   x, x_upd;
  logic [SUM_W-1:0]           sum;
  logic [NZ_W-1:0]            nz;
  logic [IDX_W-1:0]           nz_idx;
  logic                       settled, limit_hit;

  maxnet_sum_tree #(.M(M), .DATA_W(DATA_W)) u_sum (
    .x   (x),
    .sum (sum)
  );

  always_comb begin
    nz     = '0;
    nz_idx = '0;
    for (int i = 0; i < M; i++) begin
      if (x[i] != '0) begin
        nz     = nz + NZ_W'(1);
        nz_idx = IDX_W'(i);
      end
    end
  end

  assign settled = (nz <= NZ_W'(1));

  genvar g;
  generate
    for (g = 0; g < M; g++) begin : g_node
      logic [SUM_W-1:0] rest, inh;
      data_t            inh_sat;
      assign rest = sum - SUM_W'(x[g]);
      // A zero shift result with live competitors still inhibits by 1 so the run terminates.
      assign inh  = ((rest >> EPS_SHIFT) == '0 && rest != '0) ? SUM_W'(1) : (rest >> EPS_SHIFT);
      assign inh_sat  = (inh > SUM_W'({DATA_W{1'b1}})) ? '1 : inh[DATA_W-1:0];
      assign x_upd[g] = sat_sub(x[g], inh_sat);
    end
  endgenerate

`ifdef MAXNET_TIMEOUT_EN
  assign limit_hit = (iter_count == ITER_W'(MAX_ITER));
`else
  assign limit_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (settled || limit_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      x            <= '0;
      iter_count   <= '0;
      winner_valid <= 1'b0;
      winner_idx   <= '0;
      winner_val   <= '0;
`ifdef MAXNET_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          x            <= po;
          iter_count   <= '0;
          winner_valid <= 1'b0;
          winner_idx   <= '0;
          winner_val   <= '0;
`ifdef MAXNET_TIMEOUT_EN
          timeout      <= 1'b0;
`endif
        end
        RUN: begin
          if (settled) begin
            winner_valid <= (nz == NZ_W'(1));
            winner_idx   <= (nz == NZ_W'(1)) ? nz_idx : '0;
            winner_val   <= (nz == NZ_W'(1)) ? x[nz_idx] : '0;
          end else if (limit_hit) begin
`ifdef MAXNET_TIMEOUT_EN
            timeout      <= 1'b1;
`endif
          end else begin
            x          <= x_upd;
            iter_count <= iter_count + ITER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_maxnet_engine.sv
// Self-checking bench for maxnet_engine: directed table, corner sequences and random vs. model.
module tb_maxnet_engine;
  localparam int M = 10;
  localparam int EPS_SHIFT = 4;
`ifdef MAXNET_TIMEOUT_EN
  localparam int TB_MAX_ITER = 2;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TB_MAX_ITER = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [M-1:0][7:0] po = '0;
  logic busy, done, winner_valid, timeout;
  logic [3:0] winner_idx;
  logic [7:0] winner_val, iter_count;

  int n_vec = 0, n_err = 0;

  maxnet_engine #(.M(M), .EPS_SHIFT(EPS_SHIFT), .MAX_ITER(TB_MAX_ITER)) dut (
    .clk(clk), .reset(reset), .start(start), .po(po), .busy(busy), .done(done),
    .winner_valid(winner_valid), .winner_idx(winner_idx), .winner_val(winner_val),
    .iter_count(iter_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: iterate the inhibition rule on plain integers.
  task automatic ref_model(input logic [M-1:0][7:0] p, output int it, output int v,
                           output int idx, output int val, output int to);
    int x[M], nx[M], total, nzc, d, inh;
    for (int i = 0; i < M; i++) x[i] = int'(p[i]);
    it = 0; to = 0;
    forever begin
      nzc = 0; total = 0;
      for (int i = 0; i < M; i++) begin
        total += x[i];
        if (x[i] != 0) nzc++;
      end
      if (nzc <= 1) break;
      if (TO_EN && it == TB_MAX_ITER) begin to = 1; break; end
      for (int i = 0; i < M; i++) begin
        d   = total - x[i];
        inh = d / (1 << EPS_SHIFT);
        if (inh == 0 && d != 0) inh = 1;
        nx[i] = (x[i] > inh) ? x[i] - inh : 0;
      end
      x = nx;
      it++;
    end
    v = 0; idx = 0; val = 0;
    if (!to && nzc == 1)
      for (int i = 0; i < M; i++)
        if (x[i] != 0) begin v = 1; idx = i; val = x[i]; end
  endtask

  task automatic run(input logic [M-1:0][7:0] p, input int poke, output int lat,
                     output int v, output int idx, output int val, output int it, output int to);
    @(negedge clk); po = p; start = 1'b1;
    @(negedge clk); start = 1'b0; po = {$urandom, $urandom, $urandom};
    lat = 1;
    check("busy_after_start", int'(busy), 1);
    while (!done && lat < 600) begin
      if (lat == poke) begin start = 1'b1; po = ~p; end
      else start = 1'b0;
      @(negedge clk); lat++;
    end
    start = 1'b0;
    if (!done) check("done_within_budget", 0, 1);
    v = int'(winner_valid); idx = int'(winner_idx); val = int'(winner_val);
    it = int'(iter_count); to = int'(timeout);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("result_hold", int'(winner_val), val);
  endtask

  typedef struct packed {
    logic [M-1:0][7:0] po;
    logic [7:0]        it;
    logic              v;
    logic [3:0]        idx;
    logic [7:0]        val;
    logic              to;
  } vec_t;

  task automatic compare(input string tag, input int lat, input int v, input int idx,
                         input int val, input int it, input int to, input int e_it,
                         input int e_v, input int e_idx, input int e_val, input int e_to);
    check({tag, "_latency"}, lat, 3 + e_it);
    check({tag, "_iter"}, it, e_it);
    check({tag, "_valid"}, v, e_v);
    check({tag, "_idx"}, idx, e_idx);
    check({tag, "_val"}, val, e_val);
    check({tag, "_timeout"}, to, e_to);
  endtask

  initial begin
    vec_t tbl[5];
    logic [M-1:0][7:0] p;
    int lat, v, idx, val, it, to, e_it, e_v, e_idx, e_val, e_to;

    p = '0; p[2] = 8'd50;               tbl[0] = '{p, 8'd0, 1'b1, 4'd2, 8'd50, 1'b0};
    p = '0;                             tbl[1] = '{p, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0};
    p = {M{8'd5}};                      tbl[2] = '{p, 8'd4, 1'b0, 4'd0, 8'd0, 1'b0};
    p = '0; p[1] = 8'd100; p[7] = 8'd60; tbl[3] = '{p, 8'd12, 1'b1, 4'd1, 8'd79, 1'b0};
    p = '0; p[9] = 8'd255;              tbl[4] = '{p, 8'd0, 1'b1, 4'd9, 8'd255, 1'b0};
`ifdef MAXNET_TIMEOUT_EN
    tbl[2].it = 8'd2; tbl[2].to = 1'b1;
    tbl[3].it = 8'd2; tbl[3].to = 1'b1; tbl[3].v = 1'b0; tbl[3].idx = '0; tbl[3].val = '0;
`endif

    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_iter", int'(iter_count), 0);
    check("reset_valid", int'(winner_valid), 0);
    check("reset_timeout", int'(timeout), 0);
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run(tbl[t].po, 0, lat, v, idx, val, it, to);
      compare($sformatf("tbl%0d", t), lat, v, idx, val, it, to,
              int'(tbl[t].it), int'(tbl[t].v), int'(tbl[t].idx), int'(tbl[t].val), int'(tbl[t].to));
    end

    // Start pulses while busy must not restart or disturb the run.
    run(tbl[2].po, 2, lat, v, idx, val, it, to);
    compare("start_while_busy", lat, v, idx, val, it, to,
            int'(tbl[2].it), int'(tbl[2].v), int'(tbl[2].idx), int'(tbl[2].val), int'(tbl[2].to));

    // Asynchronous reset mid-run.
    @(negedge clk); po = tbl[3].po; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1; #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_iter", int'(iter_count), 0);
    check("rst_valid", int'(winner_valid), 0);
    check("rst_idx", int'(winner_idx), 0);
    check("rst_val", int'(winner_val), 0);
    check("rst_timeout", int'(timeout), 0);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_done_after_reset", int'(done), 0);
    end
    run(tbl[0].po, 0, lat, v, idx, val, it, to);
    compare("after_reset", lat, v, idx, val, it, to, 0, 1, 2, 50, 0);

    // Random sparse vectors against the reference model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < M; i++)
        p[i] = ($urandom_range(0, 9) < 4) ? 8'($urandom_range(1, 255)) : 8'd0;
      if (r % 8 == 7) begin p = '0; p[r % M] = 8'd77; p[(r + 3) % M] = 8'd77; end
      ref_model(p, e_it, e_v, e_idx, e_val, e_to);
      run(p, (r % 3 == 0) ? 2 : 0, lat, v, idx, val, it, to);
      compare($sformatf("rnd%0d", r), lat, v, idx, val, it, to, e_it, e_v, e_idx, e_val, e_to);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
